// File: rtl/sha256_stream_core.sv
// ---------------------------------------------------------------------------
// sha256_stream_core
//
// Streaming SHA-256 compression engine. Accepts 512-bit message blocks over a
// valid/ready handshake, chains the hash state H across the blocks of a
// message, and runs ROUNDS_PER_CYCLE compression rounds per clock. The final
// digest is held on out_hash with out_valid until out_ready is seen.
//
// Parameters
//   ROUNDS_PER_CYCLE  rounds per clock, 1/2/4/8 (others fail elaboration)
//   BLK_CNT_W         width of blk_count
//
// Ports
//   clk        clock, rising edge
//   reset_n    synchronous active-low reset
//   in_valid   in_block/in_first/in_last/iv valid
//   in_ready   core can accept a block (IDLE and not in reset)
//   in_block   message block, word 0 in [511:480]
//   in_first   block starts a new message, chain from iv
//   in_last    block ends the message, present digest
//   iv         initial hash, h0 in [255:224]
//   out_valid  digest valid (HOLD)
//   out_ready  digest consumer ready
//   out_hash   chaining state H, h0 in [255:224]
//   blk_count  blocks completed since last in_first
//   busy       engine not idle
//   mid_valid  (SHA256_MIDSTATE_OUT_EN only) one-cycle pulse after every
//              non-last block; out_hash then carries the midstate
//
// Build option: define SHA256_MIDSTATE_OUT_EN to add the mid_valid port.
// ---------------------------------------------------------------------------
module sha256_stream_core #(
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter int BLK_CNT_W        = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [511:0]         in_block,
   input  logic                 in_first,
   input  logic                 in_last,
   input  logic [255:0]         iv,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [255:0]         out_hash,
   output logic [BLK_CNT_W-1:0] blk_count,
   output logic                 busy
`ifdef SHA256_MIDSTATE_OUT_EN
   ,
   output logic                 mid_valid
`endif
);

   localparam int R = ROUNDS_PER_CYCLE;

   if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds
      $error("sha256_stream_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
   end

   localparam logic [255:0] FIPS_IV =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic [1:0] {IDLE, COMPUTE, FINAL, HOLD} state_t;

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
   endfunction

   // One compression round on the packed working state {a,b,c,d,e,f,g,h}.
   function automatic logic [255:0] round_step(input logic [255:0] s,
                                               input logic [31:0]  kt,
                                               input logic [31:0]  wt);
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      {a, b, c, d, e, f, g, h} = s;
      t1 = h + big_sigma1(e) + ((e & f) ^ (~e & g)) + kt + wt;
      t2 = big_sigma0(a) + ((a & b) ^ (a & c) ^ (b & c));
      return {t1 + t2, a, b, c, d + t1, e, f, g};
   endfunction

   // Word-wise mod 2^32 addition of two packed 8-word states.
   function automatic logic [255:0] add_words(input logic [255:0] x,
                                              input logic [255:0] y);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) begin
         r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
      end
      return r;
   endfunction

   state_t               state;
   logic [5:0]           round;
   logic                 last_q;
   logic [255:0]         hash_q;
   logic [255:0]         work_q;
   logic [31:0]          win [16];
   logic [BLK_CNT_W-1:0] blk_cnt_q;
   logic                 out_valid_q;
   logic                 busy_q;
   logic                 in_ready_q;
   logic                 acc;

   logic [31:0]          ext [16+R];
   logic [255:0]         st  [R+1];

   assign in_ready  = in_ready_q & reset_n;
   assign acc       = in_valid & in_ready;
   assign out_valid = out_valid_q;
   assign out_hash  = hash_q;
   assign blk_count = blk_cnt_q;
   assign busy      = busy_q;

   // Schedule window extended by R words; window entry 0 is always W[round],
   // so the same expansion serves rounds below and above 16.
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         ext[i] = win[i];
      end
      for (int j = 0; j < R; j++) begin
         ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j] + small_sigma0(ext[1+j]) + ext[j];
      end
      st[0] = work_q;
      for (int k = 0; k < R; k++) begin
         st[k+1] = round_step(st[k], K[round + 6'(k)], ext[k]);
      end
   end

   // Datapath registers: no reset, contents only meaningful after an accept.
   always_ff @(posedge clk) begin
      if (acc) begin
         for (int i = 0; i < 16; i++) begin
            win[i] <= in_block[511 - 32*i -: 32];
         end
         work_q <= in_first ? iv : hash_q;
      end else if (state == COMPUTE) begin
         for (int i = 0; i < 16; i++) begin
            win[i] <= ext[R+i];
         end
         work_q <= st[R];
      end
   end

   // Control FSM and chaining state.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         round       <= '0;
         last_q      <= 1'b0;
         hash_q      <= FIPS_IV;
         blk_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b1;
`ifdef SHA256_MIDSTATE_OUT_EN
         mid_valid   <= 1'b0;
`endif
      end else begin
`ifdef SHA256_MIDSTATE_OUT_EN
         mid_valid <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (acc) begin
                  last_q     <= in_last;
                  round      <= '0;
                  busy_q     <= 1'b1;
                  in_ready_q <= 1'b0;
                  state      <= COMPUTE;
                  if (in_first) begin
                     hash_q    <= iv;
                     blk_cnt_q <= '0;
                  end
               end
            end
            COMPUTE: begin
               round <= round + 6'(R);
               if (round == 6'(64 - R)) begin
                  state <= FINAL;
               end
            end
            FINAL: begin
               hash_q    <= add_words(hash_q, work_q);
               blk_cnt_q <= blk_cnt_q + 1'b1;
               if (last_q) begin
                  state       <= HOLD;
                  out_valid_q <= 1'b1;
               end else begin
                  state      <= IDLE;
                  busy_q     <= 1'b0;
                  in_ready_q <= 1'b1;
`ifdef SHA256_MIDSTATE_OUT_EN
                  mid_valid  <= 1'b1;
`endif
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_stream_core.sv
// ---------------------------------------------------------------------------
// tb_sha256_stream_core
//
// Directed bench for sha256_stream_core. Three instances (1, 4 and 8 rounds
// per clock) share the data inputs; in_valid/out_ready are steered to the
// instance selected by cur_r and its outputs are muxed back for checking.
// Known-answer digests: "abc", the 448-bit two-block message, and the empty
// message.
// ---------------------------------------------------------------------------
module tb_sha256_stream_core;

   localparam logic [255:0] FIPS = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};
   localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
   localparam logic [511:0] TWO_B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] TWO_B2 = {448'h0, 64'h1c0};
   localparam logic [255:0] D_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] D_TWO = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
   localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

   typedef struct {
      string        name;
      logic [511:0] blk;
      logic         first;
      logic         last;
      logic [255:0] ivv;
      int           r;
      logic         chk_hash;
      logic [255:0] exp_hash;
      int           exp_lat;
      int           exp_cnt;
   } vec_t;

   logic         clk;
   logic         reset_n;
   logic         in_valid;
   logic         out_ready;
   logic [511:0] in_block;
   logic         in_first;
   logic         in_last;
   logic [255:0] iv;
   int           cur_r;

   logic         in_ready_1, out_valid_1, busy_1, mid_valid_1;
   logic         in_ready_4, out_valid_4, busy_4, mid_valid_4;
   logic         in_ready_8, out_valid_8, busy_8, mid_valid_8;
   logic [255:0] out_hash_1, out_hash_4, out_hash_8;
   logic [15:0]  blk_count_1, blk_count_4, blk_count_8;

   logic         s_in_ready, s_out_valid, s_busy, s_mid;
   logic [255:0] s_hash;
   logic [15:0]  s_cnt;

   int           n_chk;
   int           n_err;
   int           mid_cnt;
   int           mid_cyc;
   logic [255:0] mid_hash;
   vec_t         tbl [10];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   sha256_stream_core #(.ROUNDS_PER_CYCLE(1), .BLK_CNT_W(16)) u_r1 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid && cur_r == 1), .in_ready(in_ready_1),
      .in_block(in_block), .in_first(in_first), .in_last(in_last), .iv(iv),
      .out_valid(out_valid_1), .out_ready(out_ready && cur_r == 1), .out_hash(out_hash_1),
      .blk_count(blk_count_1), .busy(busy_1)
`ifdef SHA256_MIDSTATE_OUT_EN
      , .mid_valid(mid_valid_1)
`endif
   );

   sha256_stream_core #(.ROUNDS_PER_CYCLE(4), .BLK_CNT_W(16)) u_r4 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid && cur_r == 4), .in_ready(in_ready_4),
      .in_block(in_block), .in_first(in_first), .in_last(in_last), .iv(iv),
      .out_valid(out_valid_4), .out_ready(out_ready && cur_r == 4), .out_hash(out_hash_4),
      .blk_count(blk_count_4), .busy(busy_4)
`ifdef SHA256_MIDSTATE_OUT_EN
      , .mid_valid(mid_valid_4)
`endif
   );

   sha256_stream_core #(.ROUNDS_PER_CYCLE(8), .BLK_CNT_W(16)) u_r8 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid && cur_r == 8), .in_ready(in_ready_8),
      .in_block(in_block), .in_first(in_first), .in_last(in_last), .iv(iv),
      .out_valid(out_valid_8), .out_ready(out_ready && cur_r == 8), .out_hash(out_hash_8),
      .blk_count(blk_count_8), .busy(busy_8)
`ifdef SHA256_MIDSTATE_OUT_EN
      , .mid_valid(mid_valid_8)
`endif
   );

`ifndef SHA256_MIDSTATE_OUT_EN
   assign mid_valid_1 = 1'b0;
   assign mid_valid_4 = 1'b0;
   assign mid_valid_8 = 1'b0;
`endif

   always_comb begin
      s_in_ready  = in_ready_1;
      s_out_valid = out_valid_1;
      s_busy      = busy_1;
      s_mid       = mid_valid_1;
      s_hash      = out_hash_1;
      s_cnt       = blk_count_1;
      if (cur_r == 4) begin
         s_in_ready  = in_ready_4;
         s_out_valid = out_valid_4;
         s_busy      = busy_4;
         s_mid       = mid_valid_4;
         s_hash      = out_hash_4;
         s_cnt       = blk_count_4;
      end else if (cur_r == 8) begin
         s_in_ready  = in_ready_8;
         s_out_valid = out_valid_8;
         s_busy      = busy_8;
         s_mid       = mid_valid_8;
         s_hash      = out_hash_8;
         s_cnt       = blk_count_8;
      end
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string n, input logic [511:0] b, input logic f, input logic l,
                               input logic [255:0] ivv, input int r, input logic ch,
                               input logic [255:0] eh, input int lat, input int cnt);
      vec_t v;
      v.name = n; v.blk = b; v.first = f; v.last = l; v.ivv = ivv; v.r = r;
      v.chk_hash = ch; v.exp_hash = eh; v.exp_lat = lat; v.exp_cnt = cnt;
      return v;
   endfunction

   // Send one block, wait (bounded) for the digest or for in_ready to return,
   // and check latency, digest and block count.
   task automatic apply(input vec_t v);
      int   cyc;
      logic done;
      logic saw_ov;
      cur_r = v.r;
      @(negedge clk);
      cyc = 0;
      while (!s_in_ready && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk({v.name, " in_ready before send"}, 256'(s_in_ready), 256'(1));
      in_block = v.blk;
      in_first = v.first;
      in_last  = v.last;
      iv       = v.ivv;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 0; done = 1'b0; saw_ov = 1'b0; mid_cnt = 0;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (s_mid) begin
            mid_cnt++;
            mid_cyc  = cyc;
            mid_hash = s_hash;
         end
         if (v.last) begin
            done = s_out_valid;
         end else begin
            if (s_out_valid) saw_ov = 1'b1;
            done = s_in_ready;
         end
      end
      chk({v.name, " latency"}, 256'(cyc), 256'(v.exp_lat));
      if (!v.last) chk({v.name, " no out_valid"}, 256'(saw_ov), 256'(0));
      if (v.chk_hash) chk({v.name, " out_hash"}, s_hash, v.exp_hash);
      chk({v.name, " blk_count"}, 256'(s_cnt), 256'(v.exp_cnt));
      if (v.last) begin
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         chk({v.name, " out_valid drop"}, 256'(s_out_valid), 256'(0));
         chk({v.name, " in_ready after"}, 256'(s_in_ready), 256'(1));
      end
   endtask

   initial begin
      int   cyc;
      logic saw_ov;
      vec_t v;
      n_chk = 0; n_err = 0; mid_cnt = 0; mid_cyc = 0; mid_hash = '0;
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cur_r = 1;
      in_block = '0; in_first = 1'b0; in_last = 1'b0; iv = '0;

      tbl[0] = mk("abc r1",     ABC_BLK,   1'b1, 1'b1, FIPS, 1, 1'b1, D_ABC,   65, 1);
      tbl[1] = mk("two b1 r1",  TWO_B1,    1'b1, 1'b0, FIPS, 1, 1'b0, '0,      65, 1);
      tbl[2] = mk("two b2 r1",  TWO_B2,    1'b0, 1'b1, '0,   1, 1'b1, D_TWO,   65, 2);
      tbl[3] = mk("abc r4",     ABC_BLK,   1'b1, 1'b1, FIPS, 4, 1'b1, D_ABC,   17, 1);
      tbl[4] = mk("abc r8",     ABC_BLK,   1'b1, 1'b1, FIPS, 8, 1'b1, D_ABC,   9,  1);
      tbl[5] = mk("empty r1",   EMPTY_BLK, 1'b1, 1'b1, FIPS, 1, 1'b1, D_EMPTY, 65, 1);
      tbl[6] = mk("two b1 r8",  TWO_B1,    1'b1, 1'b0, FIPS, 8, 1'b0, '0,      9,  1);
      tbl[7] = mk("two b2 r8",  TWO_B2,    1'b0, 1'b1, '0,   8, 1'b1, D_TWO,   9,  2);
      tbl[8] = mk("two b1 r4",  TWO_B1,    1'b1, 1'b0, FIPS, 4, 1'b0, '0,      17, 1);
      tbl[9] = mk("two b2 r4",  TWO_B2,    1'b0, 1'b1, '0,   4, 1'b1, D_TWO,   17, 2);

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset out_valid", 256'(s_out_valid), 256'(0));
      chk("reset busy", 256'(s_busy), 256'(0));
      chk("reset out_hash", s_hash, FIPS);
      chk("reset blk_count", 256'(s_cnt), 256'(0));
      chk("reset in_ready low", 256'(s_in_ready), 256'(0));
      reset_n = 1'b1;
      @(negedge clk);
      chk("post-reset in_ready", 256'(s_in_ready), 256'(1));

      for (int i = 0; i < 10; i++) begin
         apply(tbl[i]);
      end

      // Backpressure in HOLD on the 4-round instance
      cur_r = 4;
      @(negedge clk);
      in_block = ABC_BLK; in_first = 1'b1; in_last = 1'b1; iv = FIPS; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 0;
      while (!s_out_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("bp latency", 256'(cyc), 256'(17));
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_first = 1'b1; in_last = 1'b0; iv = ~FIPS; in_block = EMPTY_BLK;
         @(negedge clk);
         chk("bp out_valid held", 256'(s_out_valid), 256'(1));
         chk("bp out_hash stable", s_hash, D_ABC);
         chk("bp in_ready low", 256'(s_in_ready), 256'(0));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp release out_valid", 256'(s_out_valid), 256'(0));
      chk("bp release in_ready", 256'(s_in_ready), 256'(1));
      chk("bp release busy", 256'(s_busy), 256'(0));
      chk("bp release out_hash", s_hash, D_ABC);
      chk("bp release blk_count", 256'(s_cnt), 256'(1));

      // Reset in the middle of a compression
      cur_r = 1;
      @(negedge clk);
      in_block = ABC_BLK; in_first = 1'b1; in_last = 1'b1; iv = '0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (30) @(negedge clk);
      chk("midrst busy before", 256'(s_busy), 256'(1));
      reset_n = 1'b0;
      @(negedge clk);
      chk("midrst out_valid", 256'(s_out_valid), 256'(0));
      chk("midrst busy", 256'(s_busy), 256'(0));
      chk("midrst out_hash", s_hash, FIPS);
      chk("midrst blk_count", 256'(s_cnt), 256'(0));
      chk("midrst in_ready forced", 256'(s_in_ready), 256'(0));
      reset_n = 1'b1;
      @(negedge clk);
      chk("midrst in_ready", 256'(s_in_ready), 256'(1));
      saw_ov = 1'b0;
      repeat (70) begin
         @(negedge clk);
         if (s_out_valid) saw_ov = 1'b1;
      end
      chk("midrst no out_valid", 256'(saw_ov), 256'(0));
      v = mk("empty chain fips", EMPTY_BLK, 1'b0, 1'b1, '0, 1, 1'b1, D_EMPTY, 65, 1);
      apply(v);

`ifdef SHA256_MIDSTATE_OUT_EN
      // Midstate pulse: reuse the block-1 midstate as iv for block 2
      apply(tbl[1]);
      chk("mid pulse count", 256'(mid_cnt), 256'(1));
      chk("mid pulse cycle", 256'(mid_cyc), 256'(65));
      @(negedge clk);
      chk("mid pulse width", 256'(s_mid), 256'(0));
      v = mk("two b2 from mid", TWO_B2, 1'b1, 1'b1, mid_hash, 1, 1'b1, D_TWO, 65, 1);
      apply(v);
      chk("mid none on last", 256'(mid_cnt), 256'(0));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
